// File: rtl/cla_adder_pipe_if.sv
// Streaming operand/result bundle for cla_adder_pipe.
// master drives operands and consumes results; slave is the adder.
interface cla_adder_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-look-ahead adder/subtractor: one 4-bit CLA group per stage,
// inter-group carry registered, valid/ready with a single global advance enable.
module cla_adder_pipe #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          SIGNED_OVF = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  cla_adder_pipe_if.slave s_if
);
  localparam int unsigned NG = WIDTH / 4;

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
    $error("cla_adder_pipe: WIDTH=%0d must be a non-zero multiple of 4", WIDTH);
  end

  // Returns {carry out of bit 3, carry into bit 3, sum[3:0]}.
  function automatic logic [5:0] cla4(input logic [3:0] ga, input logic [3:0] gb,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = ga & gb;
    p    = ga ^ gb;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | ((&p) & c[0]);
    return {c[4], c[3], p ^ c[3:0]};
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_a_eff;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_ci_eff;
  logic             w_ov;

  logic [WIDTH-1:0] r_a [NG];
  logic [WIDTH-1:0] r_b [NG];
  logic [WIDTH-1:0] r_s [NG];
  logic [NG-1:0]    r_v;
  logic [NG-1:0]    r_c;
  logic             r_ov;

  logic [WIDTH-1:0] w_sa    [NG];
  logic [WIDTH-1:0] w_sb    [NG];
  logic [WIDTH-1:0] w_ss    [NG];
  logic [WIDTH-1:0] w_snext [NG];
  logic [5:0]       w_grp   [NG];
  logic [NG-1:0]    w_sci;
  logic [NG-1:0]    w_sv;

  assign w_adv         = !r_v[NG-1] || s_if.out_ready;
  assign s_if.in_ready = w_adv;

  // Subtract folds into the operands once; idle beats are forced to zero so
  // undefined inputs never enter the datapath.
  assign w_a_eff  = s_if.in_valid ? s_if.a : '0;
  assign w_b_eff  = s_if.in_valid ? (s_if.sub ? ~s_if.b : s_if.b) : '0;
  assign w_ci_eff = s_if.in_valid & (s_if.sub ? ~s_if.c_in : s_if.c_in);

  always_comb begin
    w_sa[0]  = w_a_eff;
    w_sb[0]  = w_b_eff;
    w_ss[0]  = '0;
    w_sci[0] = w_ci_eff;
    w_sv[0]  = s_if.in_valid;
    for (int unsigned k = 1; k < NG; k++) begin
      w_sa[k]  = r_a[k-1];
      w_sb[k]  = r_b[k-1];
      w_ss[k]  = r_s[k-1];
      w_sci[k] = r_c[k-1];
      w_sv[k]  = r_v[k-1];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NG; k++) begin
      w_grp[k]            = cla4(w_sa[k][4*k +: 4], w_sb[k][4*k +: 4], w_sci[k]);
      w_snext[k]          = w_ss[k];
      w_snext[k][4*k +: 4] = w_grp[k][3:0];
    end
    w_ov = SIGNED_OVF ? (w_grp[NG-1][4] ^ w_grp[NG-1][5]) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v  <= '0;
      r_c  <= '0;
      r_ov <= 1'b0;
      for (int unsigned k = 0; k < NG; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else if (w_adv) begin
      r_v  <= w_sv;
      r_ov <= w_ov;
      for (int unsigned k = 0; k < NG; k++) begin
        r_a[k] <= w_sa[k];
        r_b[k] <= w_sb[k];
        r_s[k] <= w_snext[k];
        r_c[k] <= w_grp[k][5];
      end
    end
  end

  assign s_if.out_valid = r_v[NG-1];
  assign s_if.sum       = r_s[NG-1];
  assign s_if.c_out     = r_c[NG-1];
  assign s_if.overflow  = r_ov;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed and random checks of cla_adder_pipe (WIDTH=16) against an
// integer-arithmetic reference model and an in-order expected-result queue.
module tb_cla_adder_pipe;
  localparam int unsigned W   = 16;
  localparam int unsigned LAT = W / 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_adder_pipe_if #(.WIDTH(W)) bus ();

  cla_adder_pipe #(.WIDTH(W), .SIGNED_OVF(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s_if (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  logic [W+1:0] q[$];
  logic [W+1:0] exp_cur;
  logic [W+1:0] held;
  logic         hold_prev = 1'b0;
  logic         acc;
  logic         chk_rdy = 1'b0;
  logic         exp_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {overflow, c_out, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci, input logic s);
    longint ua, ub, ic, sa, sb, us, ss, smax, smin;
    logic   co, ov;
    logic [W-1:0] r;
    ua = longint'(a);
    ub = longint'(b);
    ic = longint'(ci);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    us = s ? (ua - ub - ic) : (ua + ub + ic);
    ss = s ? (sa - sb - ic) : (sa + sb + ic);
    co = s ? (us >= 0) : (us >= (longint'(1) << W));
    ov = (ss > smax) || (ss < smin);
    r  = us[W-1:0];
    return {ov, co, r};
  endfunction

  function automatic logic [W+1:0] out3();
    return {bus.overflow, bus.c_out, bus.sum};
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic s);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = ci;
    bus.sub      = s;
  endtask

  // One cycle: inspect at negedge, score the handshakes of the coming edge.
  task automatic tick();
    @(negedge clk);
    if (chk_rdy) chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (hold_prev) chk("held_output", 32'(out3()), 32'(held));
    if (bus.out_valid && bus.out_ready) begin
      n_checks++;
      assert (q.size() > 0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL extra_beat observed=0x%0h expected=none", out3());
      end
      if (q.size() > 0) chk("result", 32'(out3()), 32'(q.pop_front()));
    end
    hold_prev = bus.out_valid && !bus.out_ready;
    held      = out3();
    acc       = bus.in_valid && bus.in_ready;
    if (acc) q.push_back(exp_cur);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && (q.size() > 0 || bus.out_valid); i++) tick();
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  logic [W-1:0] d_a  [6] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h0005};
  logic [W-1:0] d_b  [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0003};
  logic         d_ci [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic         d_s  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [W+1:0] d_e  [6] = '{18'h1_0000, 18'h2_8000, 18'h3_7FFF, 18'h0_FFFF, 18'h1_0000,
                            18'h1_0001};

  logic [W-1:0] bp_a [6];
  logic [W-1:0] bp_b [6];
  logic         bp_ci[6];
  logic         bp_s [6];

  initial begin
    int unsigned bi;
    int unsigned sent;
    int unsigned guard;
    logic [W-1:0] ra, rb;
    logic         rci, rs;

    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    #3;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_outputs", 32'(out3()), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill the pipe with 3 beats under stall, then reset asynchronously.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h1234 + 16'(i), 16'h1111, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("prereset_out_valid", 32'(bus.out_valid), 32'd1);
    chk("prereset_sum", 32'(bus.sum), 32'h2345);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_outputs", 32'(out3()), 32'd0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // First beat after reset: visible after LAT edges counting the acceptance edge.
    drive(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (LAT - 2) @(posedge clk);
    #1;
    chk("latency_not_early", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
    chk("latency_result", 32'(out3()), 32'h0_0003);
    @(posedge clk); #1;
    chk("latency_no_dup", 32'(bus.out_valid), 32'd0);

    // Carry-chain, overflow and subtract corners, back-to-back mixed add/sub.
    hold_prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, d_a[i], d_b[i], d_ci[i], d_s[i]);
      exp_cur = d_e[i];
      tick();
    end
    drain();

    // Six beats with out_ready low in cycles 5..9.
    for (int i = 0; i < 6; i++) begin
      bp_a[i]  = 16'($urandom);
      bp_b[i]  = 16'($urandom);
      bp_ci[i] = 1'($urandom);
      bp_s[i]  = 1'($urandom);
    end
    bi = 0;
    chk_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bi < 6) begin
        drive(1'b1, bp_a[bi], bp_b[bi], bp_ci[bi], bp_s[bi]);
        exp_cur = ref_op(bp_a[bi], bp_b[bi], bp_ci[bi], bp_s[bi]);
      end else begin
        drive(1'b0, '0, '0, 1'b0, 1'b0);
      end
      bus.out_ready = !(c >= 5 && c <= 9);
      exp_rdy = bus.out_ready;
      tick();
      if (acc) bi++;
    end
    chk_rdy = 1'b0;
    chk("bp_beats_sent", bi, 32'd6);
    drain();

    // Random streaming with random gaps and random backpressure.
    sent = 0;
    guard = 0;
    while (sent < 3000 && guard < 20000) begin
      guard++;
      if ($urandom_range(0, 4) != 0) begin
        ra  = 16'($urandom);
        rb  = 16'($urandom);
        rci = 1'($urandom);
        rs  = 1'($urandom);
        if ($urandom_range(0, 15) == 0) begin
          ra = '1;
          rb = rs ? '1 : '0;
        end
        drive(1'b1, ra, rb, rci, rs);
        exp_cur = ref_op(ra, rb, rci, rs);
      end else begin
        drive(1'b0, 'x, 'x, 1'bx, 1'bx);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc) sent++;
    end
    chk("random_beats_sent", sent, 32'd3000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
